// File: rtl/mips_pkg.sv
// mips_pkg: shared access-size encodings and load/store FSM state type.
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD : req_size encodings (2'b11 is illegal)
//   lsu_state_t                       : IDLE, ACCESS, MERGE, RESP
package mips_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: big-endian byte/half/word lane extraction and merge.
//   word   : full memory word
//   offset : byte offset within the word
//   size   : access size (SIZE_BYTE/HALF/WORD)
//   sgn    : sign-extend extracted byte/half
//   wdata  : right-justified store data
//   rdata  : extracted, extended load data
//   merged : word with the addressed lane replaced by wdata
module lsu_lane_align
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;
    // Big-endian: byte offset o sits (3-o) bytes up, half offset o sits (2-o) bytes up.
    assign sh      = size == SIZE_BYTE ? {~offset, 3'b000} :
                     size == SIZE_HALF ? {~offset[1], 4'b0000} : 5'd0;
    assign shifted = word >> sh;
    assign rdata   = size == SIZE_BYTE ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
                     size == SIZE_HALF ? {{16{sgn & shifted[15]}}, shifted[15:0]} : word;
    assign mask    = size == SIZE_BYTE ? 32'h0000_00ff << sh :
                     size == SIZE_HALF ? 32'h0000_ffff << sh : 32'hffff_ffff;
    assign merged  = (word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-only data memory.
//   clk, reset       : clock, synchronous active-high reset
//   req_*            : valid/ready request (write, size, signed, byte address, store data)
//   resp_valid       : one-cycle completion pulse, resp_error valid alongside it
//   resp_rdata       : extended load data, held until the next load completes
//   mem_*            : word-aligned address, write strobe/data, combinational read data
module load_store_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    lsu_state_t  state, state_next;
    logic [31:0] addr_q, wdata_q, merge_q;
    logic [1:0]  size_q;
    logic        write_q, signed_q, err_q;
    logic        req_err, accept, sub_store;
    logic [31:0] lane_rdata, lane_merged;

    assign req_err   = req_size == 2'b11 || (req_size == SIZE_HALF && req_addr[0]) ||
                       (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
    assign req_ready = state == IDLE;
    assign accept    = req_valid && req_ready;
    assign sub_store = write_q && size_q != SIZE_WORD;

    lsu_lane_align u_align (
        .word   (mem_read_data),
        .offset (addr_q[1:0]),
        .size   (size_q),
        .sgn    (signed_q),
        .wdata  (wdata_q),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? (req_err ? RESP : ACCESS) : IDLE;
            ACCESS:  state_next = sub_store ? MERGE : RESP;
            MERGE:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from state; gating with reset keeps the reset cycle silent.
    assign resp_valid       = !reset && state == RESP;
    assign resp_error       = resp_valid && err_q;
    assign mem_write_enable = !reset && ((state == ACCESS && write_q && size_q == SIZE_WORD) ||
                                         state == MERGE);
    assign mem_write_data   = state == MERGE ? merge_q : wdata_q;
    assign mem_address      = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            err_q      <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= req_size;
                write_q  <= req_write;
                signed_q <= req_signed;
                err_q    <= req_err;
            end
            if (state == ACCESS && !write_q) resp_rdata <= lane_rdata;
            if (state == ACCESS) merge_q <= lane_merged;
            if (state == RESP) err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector bench for load_store_unit with a word memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        int          wrs;
        logic [31:0] rdata;
        logic [31:0] memw;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE; lat counts sampled cycles after acceptance until resp_valid.
    task automatic run(input vec_t v, output int lat, output logic err, output int wrs);
        lat = -1;
        err = 1'bx;
        wrs = 0;
        @(negedge clk);
        req_write = v.wr;
        req_size = v.sz;
        req_signed = v.sg;
        req_addr = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mem_write_enable) wrs++;
            if (resp_valid) begin
                lat = n;
                err = resp_error;
                break;
            end
        end
    endtask

    initial begin
        int lat, wrs;
        logic err;
        logic seen;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        //           wr    sz     sg    addr         wdata         lat err wrs rdata         memw
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h40, 32'hdeadbeef, 1, 1'b0, 1, 32'h00000000, 32'hdeadbeef};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        1, 1'b0, 0, 32'hdeadbeef, 32'hdeadbeef};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h41, 32'h12,       2, 1'b0, 1, 32'hdeadbeef, 32'hde12beef};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h40, 32'h0,        1, 1'b0, 0, 32'hffffffde, 32'hde12beef};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h40, 32'h0,        1, 1'b0, 0, 32'h000000de, 32'hde12beef};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h42, 32'h0,        1, 1'b0, 0, 32'hffffbeef, 32'hde12beef};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h42, 32'h0,        1, 1'b0, 0, 32'h0000beef, 32'hde12beef};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h42, 32'hffffffff, 0, 1'b1, 0, 32'h0000beef, 32'hde12beef};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h41, 32'h0,        0, 1'b1, 0, 32'h0000beef, 32'hde12beef};
        vecs[9]  = '{1'b1, 2'b11, 1'b0, 32'h40, 32'hffffffff, 0, 1'b1, 0, 32'h0000beef, 32'hde12beef};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h42, 32'ha5a5,     2, 1'b0, 1, 32'h0000beef, 32'hde12a5a5};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h43, 32'h0,        1, 1'b0, 0, 32'hffffffa5, 32'hde12a5a5};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h41, 32'h0,        1, 1'b0, 0, 32'h00000012, 32'hde12a5a5};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_error", 32'(resp_error), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset mem_address", mem_address, 32'h0);
        chk("reset mem_write_data", mem_write_data, 32'h0);
        chk("reset mem_write_enable", 32'(mem_write_enable), 32'd0);

        for (int i = 0; i < 13; i++) begin
            run(vecs[i], lat, err, wrs);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d resp_error", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("vec%0d write strobes", i), 32'(wrs), 32'(vecs[i].wrs));
            chk($sformatf("vec%0d resp_rdata", i), resp_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d mem word", i), mem[vecs[i].addr[7:2]], vecs[i].memw);
        end

        // Reset during MERGE of a half store abandons the write.
        @(negedge clk);
        req_write = 1'b1;
        req_size = 2'b01;
        req_signed = 1'b0;
        req_addr = 32'h40;
        req_wdata = 32'h5555;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("merge strobe before reset", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset-cycle strobe", 32'(mem_write_enable), 32'd0);
        chk("reset-cycle resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post-reset mem", mem[16], 32'hde12a5a5);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);
        chk("post-reset resp_rdata", resp_rdata, 32'h0);
        chk("post-reset mem_address", mem_address, 32'h0);
        chk("post-reset mem_write_data", mem_write_data, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (resp_valid || resp_error || mem_write_enable) seen = 1'b1;
            @(negedge clk);
        end
        chk("post-reset quiet", 32'(seen), 32'd0);

        // Back-to-back stores with req_valid held high.
        req_write = 1'b1;
        req_size = 2'b10;
        req_addr = 32'h48;
        req_wdata = 32'h11111111;
        req_valid = 1'b1;
        chk("b2b ready first", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_addr = 32'h4c;
        req_wdata = 32'h22222222;
        @(negedge clk);
        chk("b2b ready in ACCESS", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b ready in RESP", 32'(req_ready), 32'd0);
        chk("b2b first resp", 32'(resp_valid), 32'd1);
        @(negedge clk);
        chk("b2b ready after RESP", 32'(req_ready), 32'd1);
        chk("b2b first mem", mem[18], 32'h11111111);
        chk("b2b second not yet", mem[19], 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b second resp", 32'(resp_valid), 32'd1);
        chk("b2b second mem", mem[19], 32'h22222222);
        chk("b2b first intact", mem[18], 32'h11111111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
